uart_tx_serializer: RTL and testbench

- UART transmit serializer. It consumes the oversampling tick from the existing mod-M baud tick generator (that generator's max_tick output drives s_tick here).
- Serializes one DBIT-wide data word per frame, LSB first: 1 start bit, DBIT data bits, stop period of SB_TICK ticks.
- Sits between the transmit data source and the tx pin; it is the transmit counterpart to the UART receive path.

---
 rtl/uart_tx_serializer.sv | 135 +++++++++++++
 tb/tb_uart_tx_serializer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: sends a DBIT-wide word as one start bit, LSB-first data bits and a
// stop period, advancing only on the oversampling tick supplied by the baud tick generator.
module uart_tx_serializer #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int OS      = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            s_tick,
   input  logic            tx_start,
   input  logic [DBIT-1:0] din,
   output logic            tx_busy,
   output logic            tx_done_tick,
   output logic            tx
);

   localparam int CNT_MAX = (OS > SB_TICK) ? OS : SB_TICK;
   localparam int SW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int NW      = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [SW-1:0] OS_LAST = SW'(OS - 1);
   localparam logic [SW-1:0] SB_LAST = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t          r_state;
   state_t          w_stateNext;
   logic [SW-1:0]   r_sCnt;
   logic [SW-1:0]   w_sCntNext;
   logic [NW-1:0]   r_nCnt;
   logic [NW-1:0]   w_nCntNext;
   logic [DBIT-1:0] r_shift;
   logic [DBIT-1:0] w_shiftNext;
   logic            r_tx;
   logic            w_txNext;
   logic            w_doneTick;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_sCnt  <= '0;
         r_nCnt  <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_stateNext;
         r_sCnt  <= w_sCntNext;
         r_nCnt  <= w_nCntNext;
         r_shift <= w_shiftNext;
         r_tx    <= w_txNext;
      end
   end

   // The line value is computed for the next state, so tx switches on the same edge as the state.
   always_comb begin
      w_stateNext = r_state;
      w_sCntNext  = r_sCnt;
      w_nCntNext  = r_nCnt;
      w_shiftNext = r_shift;
      w_txNext    = r_tx;
      w_doneTick  = 1'b0;

      case (r_state)
         IDLE: begin
            w_txNext = 1'b1;
            if (tx_start) begin
               w_shiftNext = din;
               w_sCntNext  = '0;
               w_stateNext = START;
               w_txNext    = 1'b0;
            end
         end

         START: begin
            if (s_tick) begin
               if (r_sCnt == OS_LAST) begin
                  w_sCntNext  = '0;
                  w_nCntNext  = '0;
                  w_stateNext = DATA;
                  w_txNext    = r_shift[0];
               end else begin
                  w_sCntNext = r_sCnt + 1'b1;
               end
            end
         end

         DATA: begin
            if (s_tick) begin
               if (r_sCnt == OS_LAST) begin
                  w_sCntNext  = '0;
                  w_shiftNext = r_shift >> 1;
                  if (r_nCnt == N_LAST) begin
                     w_stateNext = STOP;
                     w_txNext    = 1'b1;
                  end else begin
                     w_nCntNext = r_nCnt + 1'b1;
                     w_txNext   = w_shiftNext[0];
                  end
               end else begin
                  w_sCntNext = r_sCnt + 1'b1;
               end
            end
         end

         STOP: begin
            if (s_tick) begin
               if (r_sCnt == SB_LAST) begin
                  w_sCntNext  = '0;
                  w_stateNext = IDLE;
                  w_doneTick  = 1'b1;
               end else begin
                  w_sCntNext = r_sCnt + 1'b1;
               end
            end
         end

         default: begin
            w_stateNext = IDLE;
            w_txNext    = 1'b1;
         end
      endcase
   end

   assign tx           = r_tx;
   assign tx_busy      = (r_state != IDLE);
   assign tx_done_tick = w_doneTick;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: one instance with a 1-stop-bit period and one with a
// 2-stop-bit period, both driven by a mod-4 tick generator.
module tb_uart_tx_serializer;

   logic       clk      = 1'b0;
   logic       clkEn    = 1'b0;
   logic       resetN   = 1'b1;
   logic [1:0] tickCnt  = 2'd0;
   logic       sTick;

   logic       txStart   = 1'b0;
   logic [7:0] din       = 8'h00;
   logic       txBusy;
   logic       txDone;
   logic       txLine;

   logic       txStart32 = 1'b0;
   logic [7:0] din32     = 8'h00;
   logic       txBusy32;
   logic       txDone32;
   logic       txLine32;

   int assertCount = 0;
   int failCount   = 0;

   always #5 if (clkEn) clk = ~clk;

   // Stand-in for the baud generator with M=4: one-clk tick every fourth clock.
   always @(posedge clk) tickCnt <= tickCnt + 2'd1;
   assign sTick = (tickCnt == 2'd3);

   uart_tx_serializer #(.DBIT(8), .SB_TICK(16), .OS(16)) dut (
      .clk          (clk),
      .reset_n      (resetN),
      .s_tick       (sTick),
      .tx_start     (txStart),
      .din          (din),
      .tx_busy      (txBusy),
      .tx_done_tick (txDone),
      .tx           (txLine)
   );

   uart_tx_serializer #(.DBIT(8), .SB_TICK(32), .OS(16)) dut32 (
      .clk          (clk),
      .reset_n      (resetN),
      .s_tick       (sTick),
      .tx_start     (txStart32),
      .din          (din32),
      .tx_busy      (txBusy32),
      .tx_done_tick (txDone32),
      .tx           (txLine32)
   );

   function automatic logic lineOf(input logic sel);
      return sel ? txLine32 : txLine;
   endfunction

   function automatic logic busyOf(input logic sel);
      return sel ? txBusy32 : txBusy;
   endfunction

   function automatic logic doneOf(input logic sel);
      return sel ? txDone32 : txDone;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Drives a one-clk start request; optionally lands it on a tick so the accepting edge coincides.
   task automatic applyStimulus(input logic sel, input logic [7:0] data, input logic alignTick);
      @(negedge clk);
      if (alignTick) begin
         for (int i = 0; i < 8 && sTick !== 1'b1; i++) @(negedge clk);
      end
      if (sel) begin
         din32 = data;
         txStart32 = 1'b1;
      end else begin
         din = data;
         txStart = 1'b1;
      end
      @(negedge clk);
      txStart   = 1'b0;
      txStart32 = 1'b0;
   endtask

   // Walks one frame tick by tick from the first low sample; returns at the done-pulse negedge.
   task automatic checkFrame(input logic sel, input logic [7:0] data, input string tag, output int startClks);
      int   budget;
      int   ticks;
      int   bitTicks;
      int   clks;
      int   glitches;
      int   busyLow;
      int   doneHits;
      int   badLen;
      logic expBit;
      logic midVal;

      startClks = 0;
      budget = 0;
      while (lineOf(sel) !== 1'b0 && budget < 1000) begin
         @(negedge clk);
         budget++;
      end
      if (lineOf(sel) !== 1'b0) begin
         checkOutput({tag, " start timeout"}, 32'(lineOf(sel)), 32'd0);
         return;
      end

      glitches = 0;
      busyLow  = 0;
      doneHits = 0;
      badLen   = 0;
      for (int b = 0; b < 10; b++) begin
         expBit   = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : data[b-1];
         bitTicks = (b == 9) ? (sel ? 32 : 16) : 16;
         ticks    = 0;
         clks     = 0;
         midVal   = 1'bx;
         while (ticks < bitTicks && clks < 4 * bitTicks + 20) begin
            clks++;
            if (lineOf(sel) !== expBit) glitches++;
            if (busyOf(sel) !== 1'b1) busyLow++;
            if (doneOf(sel) === 1'b1) doneHits++;
            if (sTick === 1'b1) begin
               if (ticks == bitTicks / 2) midVal = lineOf(sel);
               ticks++;
            end
            if (ticks < bitTicks || b < 9) @(negedge clk);
         end
         checkOutput($sformatf("%s bit%0d", tag, b), 32'(midVal), 32'(expBit));
         if (b == 0) startClks = clks;
         else if (b < 9 && clks != 64) badLen++;
         else if (b == 9) checkOutput({tag, " stop clks"}, 32'(clks), 32'(4 * bitTicks));
      end
      checkOutput({tag, " glitches"}, 32'(glitches), 32'd0);
      checkOutput({tag, " data bit clks"}, 32'(badLen), 32'd0);
      checkOutput({tag, " busy low in frame"}, 32'(busyLow), 32'd0);
      checkOutput({tag, " done at end"}, 32'(doneOf(sel)), 32'd1);
      checkOutput({tag, " done count"}, 32'(doneHits), 32'd1);
   endtask

   // Watches the line for a while with no request pending; nothing should move.
   task automatic checkIdle(input logic sel, input int nClks, input string tag);
      int txLow;
      int busyHigh;
      int doneHits;
      txLow = 0;
      busyHigh = 0;
      doneHits = 0;
      for (int i = 0; i < nClks; i++) begin
         @(negedge clk);
         if (lineOf(sel) !== 1'b1) txLow++;
         if (busyOf(sel) !== 1'b0) busyHigh++;
         if (doneOf(sel) !== 1'b0) doneHits++;
      end
      checkOutput({tag, " tx low"}, 32'(txLow), 32'd0);
      checkOutput({tag, " busy"}, 32'(busyHigh), 32'd0);
      checkOutput({tag, " done"}, 32'(doneHits), 32'd0);
   endtask

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int sc;

      // Asynchronous reset with the clock stopped.
      #2 resetN = 1'b0;
      #2;
      checkOutput("reset tx", 32'(txLine), 32'd1);
      checkOutput("reset busy", 32'(txBusy), 32'd0);
      checkOutput("reset done", 32'(txDone), 32'd0);
      checkOutput("reset tx32", 32'(txLine32), 32'd1);

      clkEn = 1'b1;
      repeat (3) @(negedge clk);
      resetN = 1'b1;
      checkIdle(1'b0, 100, "post reset");

      // Single frame 0xA5.
      applyStimulus(1'b0, 8'hA5, 1'b0);
      checkFrame(1'b0, 8'hA5, "A5", sc);
      checkOutput("A5 start clks in range", 32'(sc >= 61 && sc <= 64), 32'd1);
      checkIdle(1'b0, 20, "A5 after");

      // Request during DATA of a 0x3C frame must be ignored.
      applyStimulus(1'b0, 8'h3C, 1'b0);
      fork
         checkFrame(1'b0, 8'h3C, "3C", sc);
         begin
            repeat (200) @(negedge clk);
            din = 8'hFF;
            txStart = 1'b1;
            @(negedge clk);
            txStart = 1'b0;
         end
      join
      checkIdle(1'b0, 300, "3C no second frame");

      // Back-to-back frames with tx_start held high.
      @(negedge clk);
      din = 8'h00;
      txStart = 1'b1;
      @(negedge clk);
      checkFrame(1'b0, 8'h00, "b2b first", sc);
      din = 8'hFF;
      @(negedge clk);
      checkOutput("b2b gap busy", 32'(txBusy), 32'd0);
      checkOutput("b2b gap tx", 32'(txLine), 32'd1);
      @(negedge clk);
      checkOutput("b2b restart busy", 32'(txBusy), 32'd1);
      checkOutput("b2b restart tx", 32'(txLine), 32'd0);
      txStart = 1'b0;
      checkFrame(1'b0, 8'hFF, "b2b second", sc);
      checkIdle(1'b0, 200, "b2b no third frame");

      // Reset during the 4th data bit of 0x55 (bit3 = 0).
      applyStimulus(1'b0, 8'h55, 1'b0);
      repeat (64 + 3 * 64 + 32) @(negedge clk);
      checkOutput("abort pre tx", 32'(txLine), 32'd0);
      checkOutput("abort pre busy", 32'(txBusy), 32'd1);
      #1 resetN = 1'b0;
      #1;
      checkOutput("abort tx async", 32'(txLine), 32'd1);
      checkOutput("abort busy async", 32'(txBusy), 32'd0);
      checkOutput("abort done async", 32'(txDone), 32'd0);
      repeat (3) @(negedge clk);
      resetN = 1'b1;
      checkIdle(1'b0, 100, "abort after");
      applyStimulus(1'b0, 8'h81, 1'b0);
      checkFrame(1'b0, 8'h81, "post abort 81", sc);

      // Two-stop-bit instance, request accepted on a tick edge.
      applyStimulus(1'b1, 8'h81, 1'b1);
      checkFrame(1'b1, 8'h81, "sb32", sc);
      checkOutput("sb32 start clks", 32'(sc), 32'd64);
      checkIdle(1'b1, 50, "sb32 after");

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
